hls_to_xilly_rd: RTL
====================

HLS_TO_XILLY_RD -- requirements
Module: hls_to_xilly_rd

Interface
REQ-001 SHALL have parameter DEPTH, default 16, buffer depth in words; power of two, 4..512.
REQ-002 SHALL have parameter FRAME_WORDS, default 0, words per host read session before EOF; 0 disables EOF.
REQ-003 SHALL have port bus_clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port ap_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_fifo_V_din  in  32  producer data (ap_fifo write side of the HLS core).
REQ-006 SHALL have port in_fifo_V_write  in  1  producer write strobe.
REQ-007 SHALL have port in_fifo_V_full_n  out  1  high when a word can be accepted.
REQ-008 SHALL have port user_r_read_32_rden  in  1  host read strobe.
REQ-009 SHALL have port user_r_read_32_empty  out  1  no word available to host.
REQ-010 SHALL have port user_r_read_32_data  out  32  read data, valid the cycle after an accepted rden.
REQ-011 SHALL have port user_r_read_32_eof  out  1  end of stream to host.
REQ-012 SHALL have port user_r_read_32_open  in  1  host has the device file open.
REQ-013 SHALL have port words_read  out  16  words delivered in the current session, saturating at 65535.
REQ-014 SHALL have port overflow  out  1  sticky: write attempted while full.
REQ-015 SHALL have port underflow  out  1  sticky: rden while empty.

Function
REQ-016 SHALL hold words in a circular buffer with write pointer, read pointer and count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-017 SHALL accept a producer word when in_fifo_V_write=1 and in_fifo_V_full_n=1, storing it at the write pointer and advancing it.
REQ-018 in_fifo_V_full_n SHALL be 0 exactly when count=DEPTH and open=1, combinational from registered state.
REQ-019 A write while in_fifo_V_full_n=0 SHALL be discarded and SHALL set overflow.
REQ-020 user_r_read_32_empty SHALL be 1 when count=0, or when eof=1.
REQ-021 An rden with empty=0 SHALL load data from the read pointer into user_r_read_32_data on that edge (visible next cycle), advance the read pointer and increment words_read; latency rden-to-data is 1 cycle.
REQ-022 An rden with empty=1 SHALL not change pointers, count or data, and SHALL set underflow.
REQ-023 Simultaneous accepted write and accepted read SHALL leave count unchanged; with count=0 the written word SHALL NOT be readable in the same cycle.
REQ-024 user_r_read_32_data SHALL hold its last value when no read is accepted.
REQ-025 With FRAME_WORDS>0, eof SHALL rise on the edge after the read that makes words_read equal FRAME_WORDS, and SHALL stay 1 until open=0; no further reads are accepted while eof=1.
REQ-026 With FRAME_WORDS=0, eof SHALL stay 0.
REQ-027 While eof=1, producer writes SHALL still be accepted until full.
REQ-028 While open=0: pointers, count and words_read SHALL be cleared every cycle, eof, overflow and underflow SHALL be cleared, in_fifo_V_full_n SHALL be 1, and producer writes SHALL be discarded without setting overflow.
REQ-029 An open 1->0 transition mid-transfer SHALL take effect on the next edge, discarding buffered words; data SHALL retain its value.
REQ-030 The 1->0 transition of open SHALL take priority over a same-cycle write or rden.

Reset
REQ-031 ap_rst=1 SHALL immediately force: pointers=0, count=0, data=0, eof=0, words_read=0, overflow=0, underflow=0.
REQ-032 During and after reset, empty SHALL be 1 and in_fifo_V_full_n SHALL be 1.
REQ-033 Reset deassertion SHALL be synchronised internally so the first accepted write occurs no earlier than the second bus_clk edge after release.

Verification
REQ-034 Set open=1 and write 0x11,0x22,0x33. Pulse rden 3 times -> data 0x11,0x22,0x33 each one cycle after its rden; empty=1 after the third read; words_read=3.
REQ-035 Set DEPTH=16 and write 17 words with no reads -> full_n=0 after the 16th; the 17th is dropped and overflow=1; 16 reads return words 1..16 in order.
REQ-036 Set FRAME_WORDS=4 and write 6 words. Read 4 -> eof=1 and empty=1 on the next cycle; a 5th rden sets underflow; drop open -> eof=0, count=0.
REQ-037 At count=1, assert write and rden in the same cycle -> count stays 1; read data is the older word; the next read returns the new word.
REQ-038 Assert ap_rst asynchronously mid-burst with count=5 -> outputs reach reset values without a clock edge; after release, empty=1 and full_n=1.
REQ-039 With open=0, write 0xDEADBEEF -> full_n=1, overflow=0; after open=1, empty=1.

Source files
------------

// File: rtl/hls_to_xilly_rd.sv
// Bridges an HLS ap_fifo producer to a Xillybus 32-bit read stream through a
// circular buffer, with optional per-session EOF framing and sticky error flags.
module hls_to_xilly_rd #(
    parameter int DEPTH       = 16,
    parameter int FRAME_WORDS = 0
) (
    input  logic        bus_clk,
    input  logic        ap_rst,
    input  logic [31:0] in_fifo_V_din,
    input  logic        in_fifo_V_write,
    output logic        in_fifo_V_full_n,
    input  logic        user_r_read_32_rden,
    output logic        user_r_read_32_empty,
    output logic [31:0] user_r_read_32_data,
    output logic        user_r_read_32_eof,
    input  logic        user_r_read_32_open,
    output logic [15:0] words_read,
    output logic        overflow,
    output logic        underflow
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [15:0]    LAST_WORD  = 16'(FRAME_WORDS - 1);
    localparam bit             FRAMED     = (FRAME_WORDS > 0);

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   data_q, data_d;
    logic          eof_q, eof_d;
    logic [15:0]   wordsRead_q, wordsRead_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic [1:0]    rstSync_q;

    logic          fullN;
    logic          empty;
    logic          ready;
    logic          wrAcc;
    logic          rdAcc;

    // Logic stays idle until the released reset has crossed both sync stages.
    always_ff @(posedge bus_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rstSync_q <= 2'b11;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b0};
        end
    end

    always_comb begin
        ready = ~rstSync_q[1];
        fullN = ~((count_q == FULL_COUNT) && user_r_read_32_open);
        empty = (count_q == '0) || eof_q;
        wrAcc = ready && user_r_read_32_open && in_fifo_V_write && fullN;
        rdAcc = ready && user_r_read_32_open && user_r_read_32_rden && ~empty;
    end

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        data_d      = data_q;
        eof_d       = eof_q;
        wordsRead_d = wordsRead_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // A closed device file wipes the session but keeps the last data word.
        if (!user_r_read_32_open) begin
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            count_d     = '0;
            wordsRead_d = '0;
            eof_d       = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (ready) begin
            if (wrAcc) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (rdAcc) begin
                rdPtr_d = rdPtr_q + 1'b1;
                data_d  = mem[rdPtr_q];
                if (wordsRead_q != 16'hFFFF) begin
                    wordsRead_d = wordsRead_q + 1'b1;
                end
                if (FRAMED && (wordsRead_q == LAST_WORD)) begin
                    eof_d = 1'b1;
                end
            end
            case ({wrAcc, rdAcc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (in_fifo_V_write && !fullN) begin
                overflow_d = 1'b1;
            end
            if (user_r_read_32_rden && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge bus_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            data_q      <= '0;
            eof_q       <= 1'b0;
            wordsRead_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            eof_q       <= eof_d;
            wordsRead_q <= wordsRead_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (wrAcc) begin
            mem[wrPtr_q] <= in_fifo_V_din;
        end
    end

    assign in_fifo_V_full_n     = fullN;
    assign user_r_read_32_empty = empty;
    assign user_r_read_32_data  = data_q;
    assign user_r_read_32_eof   = eof_q;
    assign words_read           = wordsRead_q;
    assign overflow             = overflow_q;
    assign underflow            = underflow_q;

endmodule
